// File: rtl/adc_cfg_pkg.sv
// Shared constants, FSM states and address decode for the ADC configuration link.
// The decode function is also used by the configuration master.
package adc_cfg_pkg;

  localparam int FRAME_BITS = 24;
  localparam int NUM_REGS   = 17;

  localparam logic [7:0] SOFT_RST_ADDR = 8'h00;
  localparam int         SOFT_RST_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } dec_t;

  function automatic dec_t addr_decode(input logic [7:0] addr);
    dec_t d;
    d.valid = 1'b1;
    d.idx   = 5'd0;
    case (addr)
      8'h00: d.idx = 5'd0;
      8'h01: d.idx = 5'd1;
      8'h0F: d.idx = 5'd2;
      8'h11: d.idx = 5'd3;
      8'h12: d.idx = 5'd4;
      8'h14: d.idx = 5'd5;
      8'h24: d.idx = 5'd6;
      8'h25: d.idx = 5'd7;
      8'h26: d.idx = 5'd8;
      8'h27: d.idx = 5'd9;
      8'h2A: d.idx = 5'd10;
      8'h2B: d.idx = 5'd11;
      8'h42: d.idx = 5'd12;
      8'h45: d.idx = 5'd13;
      8'h46: d.idx = 5'd14;
      8'hE2: d.idx = 5'd15;
      8'hE3: d.idx = 5'd16;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/adc_serial_edge.sv
// Edge detection for CS/SCLK plus SDATA alignment; 1 CLK register stage, +2 CLK when
// ADC_RESP_SYNC_EN adds a 2-flop synchroniser on all three pins. No backpressure.
module adc_serial_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_i,
  input  logic sclk_i,
  input  logic sdata_i,
  output logic sclk_rise,
  output logic cs_rise,
  output logic cs_fall,
  output logic sdata_o
);

  logic cs_s, sclk_s, sdata_s;

`ifdef ADC_RESP_SYNC_EN
  logic [1:0] cs_sync_q, cs_sync_d;
  logic [1:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] sdata_sync_q, sdata_sync_d;

  always_comb begin
    cs_sync_d    = {cs_sync_q[0], cs_i};
    sclk_sync_d  = {sclk_sync_q[0], sclk_i};
    sdata_sync_d = {sdata_sync_q[0], sdata_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q    <= '0;
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
    end else begin
      cs_sync_q    <= cs_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      sdata_sync_q <= sdata_sync_d;
    end
  end

  assign cs_s    = cs_sync_q[1];
  assign sclk_s  = sclk_sync_q[1];
  assign sdata_s = sdata_sync_q[1];
`else
  assign cs_s    = cs_i;
  assign sclk_s  = sclk_i;
  assign sdata_s = sdata_i;
`endif

  logic sclk_q, sclk_d;
  logic cs_q, cs_d;

  always_comb begin
    sclk_d = sclk_s;
    cs_d   = cs_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      cs_q   <= cs_d;
    end
  end

  // SDATA is taken from the same stage as the SCLK edge so the captured bit stays aligned.
  assign sclk_rise = !sclk_q && sclk_s;
  assign cs_rise   = !cs_q && cs_s;
  assign cs_fall   = cs_q && !cs_s;
  assign sdata_o   = sdata_s;

endmodule

// File: rtl/adc_cfg_responder.sv
// Target side of the ADC CS/SCLK/SDATA write link: 24-bit frames into a 17-entry shadow file.
// CS fall to WR_STB 2 CLK (4 with ADC_RESP_SYNC_EN); RD_DATA lags RD_IDX by 1 CLK; no backpressure.
module adc_cfg_responder
  import adc_cfg_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CS,
  input  logic             SCLK,
  input  logic             SDATA,
  input  logic [4:0]       RD_IDX,
  output logic [15:0]      RD_DATA,
  output logic             WR_STB,
  output logic [7:0]       LAST_ADDR,
  output logic [15:0]      LAST_DATA,
  output logic             FRAME_ERR,
  output logic             UNK_ADDR,
  output logic [15:0]      FRAME_CNT,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             BUSY
);

  logic sclk_rise, cs_rise, cs_fall, sdata_s;

  adc_serial_edge u_edge (
    .clk       (CLK),
    .rst_n     (RST_N),
    .cs_i      (CS),
    .sclk_i    (SCLK),
    .sdata_i   (SDATA),
    .sclk_rise (sclk_rise),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .sdata_o   (sdata_s)
  );

  state_e            state_q, state_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [23:0]       shreg_q, shreg_d;
  logic [15:0]       shadow_q [NUM_REGS];
  logic [15:0]       shadow_d [NUM_REGS];
  logic [15:0]       rd_data_q, rd_data_d;
  logic              wr_stb_q, wr_stb_d;
  logic              frame_err_q, frame_err_d;
  logic              unk_addr_q, unk_addr_d;
  logic [7:0]        last_addr_q, last_addr_d;
  logic [15:0]       last_data_q, last_data_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  dec_t              dec;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    wr_stb_d    = 1'b0;
    frame_err_d = 1'b0;
    unk_addr_d  = 1'b0;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    dec         = addr_decode(shreg_q[23:16]);
    for (int i = 0; i < NUM_REGS; i++) shadow_d[i] = shadow_q[i];

    // Reads see the pre-write contents, and out-of-map indices return zero.
    rd_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RD_IDX == 5'(i)) rd_data_d = shadow_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_rise) begin
          bitcnt_d = '0;
          shreg_d  = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          shreg_d = {shreg_q[22:0], sdata_s};
          if (bitcnt_q != 5'h1F) bitcnt_d = bitcnt_q + 5'd1;
        end
        if (cs_fall) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (bitcnt_q != 5'(FRAME_BITS)) begin
          frame_err_d = 1'b1;
          if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
        end else begin
          last_addr_d = shreg_q[23:16];
          last_data_d = shreg_q[15:0];
          if (dec.valid) begin
            if (shreg_q[23:16] == SOFT_RST_ADDR && shreg_q[SOFT_RST_BIT]) begin
              for (int i = 1; i < NUM_REGS; i++) shadow_d[i] = '0;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
              if (dec.idx == 5'(i)) shadow_d[i] = shreg_q[15:0];
            end
            wr_stb_d = 1'b1;
            if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            unk_addr_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      rd_data_q   <= '0;
      wr_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      unk_addr_q  <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      rd_data_q   <= rd_data_d;
      wr_stb_q    <= wr_stb_d;
      frame_err_q <= frame_err_d;
      unk_addr_q  <= unk_addr_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign RD_DATA   = rd_data_q;
  assign WR_STB    = wr_stb_q;
  assign LAST_ADDR = last_addr_q;
  assign LAST_DATA = last_data_q;
  assign FRAME_ERR = frame_err_q;
  assign UNK_ADDR  = unk_addr_q;
  assign FRAME_CNT = frame_cnt_q;
  assign ERR_CNT   = err_cnt_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_cfg_responder.sv
// Bench for adc_cfg_responder: directed frames, random frames and counter saturation
// against a table-driven register-file model.
module tb_adc_cfg_responder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CS = 1'b0;
  logic        SCLK = 1'b1;
  logic        SDATA = 1'b0;
  logic [4:0]  RD_IDX = 5'd0;
  logic [15:0] RD_DATA;
  logic        WR_STB;
  logic [7:0]  LAST_ADDR;
  logic [15:0] LAST_DATA;
  logic        FRAME_ERR;
  logic        UNK_ADDR;
  logic [15:0] FRAME_CNT;
  logic [7:0]  ERR_CNT;
  logic        BUSY;

  adc_cfg_responder #(.ERR_W(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CS        (CS),
    .SCLK      (SCLK),
    .SDATA     (SDATA),
    .RD_IDX    (RD_IDX),
    .RD_DATA   (RD_DATA),
    .WR_STB    (WR_STB),
    .LAST_ADDR (LAST_ADDR),
    .LAST_DATA (LAST_DATA),
    .FRAME_ERR (FRAME_ERR),
    .UNK_ADDR  (UNK_ADDR),
    .FRAME_CNT (FRAME_CNT),
    .ERR_CNT   (ERR_CNT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

`ifdef ADC_RESP_SYNC_EN
  localparam int LAT  = 4;
  localparam int SKEW = 3;
`else
  localparam int LAT  = 2;
  localparam int SKEW = 0;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0]  map_tbl [17] = '{8'h00, 8'h01, 8'h0F, 8'h11, 8'h12, 8'h14, 8'h24, 8'h25, 8'h26,
                                8'h27, 8'h2A, 8'h2B, 8'h42, 8'h45, 8'h46, 8'hE2, 8'hE3};
  logic [15:0] m_shadow [17];
  logic [7:0]  m_last_addr;
  logic [15:0] m_last_data;
  int          m_frames;
  int          m_errs;
  int          prev_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_lookup(input logic [7:0] a);
    for (int i = 0; i < 17; i++) if (map_tbl[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [15:0] m_read(input int idx);
    return (idx < 17) ? m_shadow[idx] : 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 17; i++) m_shadow[i] = 16'h0000;
    m_last_addr = 8'h00;
    m_last_data = 16'h0000;
    m_frames = 0;
    m_errs = 0;
    prev_idx = RD_IDX;
  endtask

  task automatic model_frame(input logic [31:0] bits, input int n,
                             output logic e_wr, output logic e_ferr, output logic e_unk);
    int idx;
    e_wr = 1'b0;
    e_ferr = 1'b0;
    e_unk = 1'b0;
    if (n != 24) begin
      e_ferr = 1'b1;
      m_errs = (m_errs < 255) ? m_errs + 1 : 255;
    end else begin
      m_last_addr = bits[23:16];
      m_last_data = bits[15:0];
      idx = m_lookup(bits[23:16]);
      if (idx < 0) begin
        e_unk = 1'b1;
        m_errs = (m_errs < 255) ? m_errs + 1 : 255;
      end else begin
        if (bits[23:16] == 8'h00 && bits[0]) begin
          for (int i = 1; i < 17; i++) m_shadow[i] = 16'h0000;
        end
        m_shadow[idx] = bits[15:0];
        e_wr = 1'b1;
        m_frames = (m_frames < 65535) ? m_frames + 1 : 65535;
      end
    end
  endtask

  // Drives one frame MSB first; abort_at >= 0 pulls RST_N after that many bits instead.
  task automatic send_frame(input logic [31:0] bits, input int n, input int abort_at);
    bit aborted = 1'b0;
    @(posedge CLK); #1;
    CS = 1'b1;
    SCLK = 1'b1;
    for (int b = n - 1; b >= 0; b--) begin
      if (abort_at >= 0 && (n - 1 - b) == abort_at) begin
        aborted = 1'b1;
        break;
      end
      @(posedge CLK); #1;
      SCLK = 1'b0;
      #(SKEW) SDATA = bits[b];
      @(posedge CLK); #1;
      SCLK = 1'b1;
    end
    if (aborted) begin
      @(posedge CLK); #1;
      RST_N = 1'b0;
      CS = 1'b0;
      SCLK = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
      model_reset();
    end else begin
      @(posedge CLK);
      @(negedge CLK);
      chk("busy_in_frame", BUSY, 1);
      @(posedge CLK); #1;
      CS = 1'b0;
    end
  endtask

  task automatic finish_frame(input logic e_wr, input logic e_ferr, input logic e_unk);
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge CLK);
      chk("wr_stb_timing", WR_STB, (k == LAT + 1) ? e_wr : 1'b0);
      chk("frame_err_timing", FRAME_ERR, (k == LAT + 1) ? e_ferr : 1'b0);
      chk("unk_addr_timing", UNK_ADDR, (k == LAT + 1) ? e_unk : 1'b0);
    end
    chk("last_addr", LAST_ADDR, m_last_addr);
    chk("last_data", LAST_DATA, m_last_data);
    chk("frame_cnt", FRAME_CNT, m_frames);
    chk("err_cnt", ERR_CNT, m_errs);
    chk("busy_idle", BUSY, 0);
  endtask

  task automatic do_frame(input logic [31:0] bits, input int n);
    logic e_wr, e_ferr, e_unk;
    model_frame(bits, n, e_wr, e_ferr, e_unk);
    send_frame(bits, n, -1);
    finish_frame(e_wr, e_ferr, e_unk);
  endtask

  task automatic read_check(input int idx);
    @(posedge CLK); #1;
    RD_IDX = 5'(idx);
    @(negedge CLK);
    chk("rd_data_prev", RD_DATA, m_read(prev_idx));
    @(negedge CLK);
    chk("rd_data", RD_DATA, m_read(idx));
    prev_idx = idx;
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < 17; i++) read_check(i);
    read_check(17);
    read_check(31);
  endtask

  task automatic check_reset_outputs();
    @(negedge CLK);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_wr_stb", WR_STB, 0);
    chk("rst_last_addr", LAST_ADDR, 0);
    chk("rst_last_data", LAST_DATA, 0);
    chk("rst_frame_err", FRAME_ERR, 0);
    chk("rst_unk_addr", UNK_ADDR, 0);
    chk("rst_frame_cnt", FRAME_CNT, 0);
    chk("rst_err_cnt", ERR_CNT, 0);
    chk("rst_busy", BUSY, 0);
  endtask

  initial begin
    logic [31:0] bits;
    int n;

    model_reset();
    repeat (3) @(posedge CLK);
    check_reset_outputs();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    check_reset_outputs();

    // Basic write and readback of register 0x2A.
    do_frame(32'h002A1234, 24);
    read_check(10);
    chk("scn1_rd_1234", RD_DATA, 16'h1234);

    // Short and long frames.
    do_frame($urandom & 32'h007FFFFF, 23);
    do_frame($urandom & 32'h01FFFFFF, 25);
    check_all_regs();

    // Unknown address.
    do_frame(32'h003300FF, 24);
    check_all_regs();

    // Soft reset via address 00.
    do_frame(32'h00420055, 24);
    read_check(12);
    do_frame(32'h00000001, 24);
    read_check(12);
    read_check(0);
    check_all_regs();

    // Reset in the middle of a frame.
    send_frame(32'h0011ABCD, 24, 10);
    check_reset_outputs();
    do_frame(32'h0011ABCD, 24);
    read_check(3);

    // Random frames.
    for (int t = 0; t < 30; t++) begin
      bits = $urandom;
      if ($urandom_range(0, 3) != 0) bits[23:16] = map_tbl[$urandom_range(0, 16)];
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 28)) : 24;
      do_frame(bits, n);
      read_check($urandom_range(0, 31));
    end
    check_all_regs();

    // Drive the error counter into saturation with one-bit frames.
    for (int t = 0; t < 260; t++) do_frame(32'h1, 1);
    chk("err_cnt_sat", ERR_CNT, 8'hFF);
    do_frame(32'h00E3BEEF, 24);
    read_check(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_cfg_responder.md
Name: adc_cfg_responder

Overview:
- Serial-frame responder for the ADC configuration link: it is the target side of the CS/SCLK/SDATA write protocol.
- Deserialises 24-bit MSB-first frames (8-bit register address, 16-bit data) and decodes the address to a 17-entry shadow register file.
- Flags malformed frames and exposes a registered readback port.
- Used for firmware loopback of the ADC configuration master and as an on-board ADC emulator for link self-test.

Parameters:
- FRAME_BITS, 24, number of SCLK rising edges in a valid frame.
- NUM_REGS, 17, shadow registers (indices 0..16).
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK  in  1  system clock; SCLK is generated from it at CLK/2.
- RST_N  in  1  asynchronous, active-low reset.
- CS  in  1  chip select, active high, framing the transfer.
- SCLK  in  1  serial clock, idles high.
- SDATA  in  1  serial data; launched when SCLK falls, sampled by this block on SCLK rising.
- RD_IDX  in  5  shadow register readback index.
- RD_DATA  out  16  registered readback data.
- WR_STB  out  1  one-cycle pulse on a committed register write.
- LAST_ADDR  out  8  address field of the last complete frame.
- LAST_DATA  out  16  data field of the last complete frame.
- FRAME_ERR  out  1  one-cycle pulse when the bit count is not equal to FRAME_BITS.
- UNK_ADDR  out  1  one-cycle pulse when a frame is complete but its address is not in the map.
- FRAME_CNT  out  16  saturating count of committed writes.
- ERR_CNT  out  ERR_W  saturating count of FRAME_ERR plus UNK_ADDR events.
- BUSY  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs, the shadow registers, the shift register and the bit counter are 0; FSM is in IDLE.
- Edge detect:
  - sclk_q is SCLK registered.
  - A rise is sclk_q==0 && SCLK==1.
  - cs_q is CS registered; CS rise and CS fall are detected the same way.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - On CS rise: clear bit counter and shift register, go to SHIFT.
  - SCLK edges are ignored in IDLE.
- SHIFT:
  - On each SCLK rise: shreg <= {shreg[22:0], SDATA}; bitcnt increments and saturates at 31.
  - On CS fall: go to COMMIT.
  - If an SCLK rise and a CS fall occur in the same cycle, the bit is still captured.
- COMMIT (exactly one cycle), then IDLE:
  - bitcnt != FRAME_BITS: pulse FRAME_ERR, ERR_CNT += 1; no write; LAST_* unchanged.
  - Otherwise: LAST_ADDR = shreg[23:16], LAST_DATA = shreg[15:0].
  - If the address decodes, write the shadow register at the decoded index, pulse WR_STB, FRAME_CNT += 1.
  - If it does not decode, pulse UNK_ADDR, ERR_CNT += 1.
- Address map (address to index):
  - 00→0, 01→1, 0F→2, 11→3, 12→4, 14→5, 24→6, 25→7, 26→8
  - 27→9, 2A→10, 2B→11, 42→12, 45→13, 46→14, E2→15, E3→16
  - Every other address is unknown.
- Soft reset:
  - A committed write to address 00 with data[0]=1 clears shadow registers 1..16.
  - Register 0 stores the written value.
  - WR_STB still pulses.
- Latencies:
  - CS fall to WR_STB is 2 CLK: one cycle of cs_q detection, then COMMIT.
  - RD_DATA = shadow[RD_IDX] registered, 1 CLK after RD_IDX.
  - A read of an index that is written in the same cycle returns the old value.
  - RD_IDX > 16 returns 0.
- Counters saturate: FRAME_CNT at FFFF, ERR_CNT at all-ones.
- A CS rise that occurs while in COMMIT is missed; the master's inter-frame gap is at least 2 CLK.
- RST_N asserted mid-frame aborts the frame with no write and no error.

Optional Feature:
- Macro ADC_RESP_SYNC_EN.
- Defined:
  - CS, SCLK and SDATA each pass through a 2-flop synchroniser before edge detection, allowing asynchronous or off-board sources.
  - All latencies from the pins grow by 2 CLK; CS fall to WR_STB becomes 4 CLK.
- Undefined: inputs are used directly and are assumed to be synchronous to CLK.

Decomposition:
- Package adc_cfg_pkg holds:
  - FRAME_BITS and NUM_REGS constants.
  - The FSM state enum.
  - An address-decode function returning {valid, idx[4:0]}, shared with the configuration master.
  - The soft-reset address/bit constants.
- One sub-module, adc_serial_edge, contains:
  - the optional synchroniser;
  - the sclk_q/cs_q registers;
  - the sclk_rise, cs_rise and cs_fall outputs.

Test Plan:
- Frame 0x2A1234 at SCLK=CLK/2, CS high for 48 CLK, then RD_IDX=10:
  - WR_STB 2 CLK after CS falls.
  - LAST_ADDR=2A, LAST_DATA=1234.
  - RD_DATA=1234.
  - FRAME_CNT=1.
- Frame of 23 bits, then frame of 25 bits: two FRAME_ERR pulses, ERR_CNT=2, no WR_STB, LAST_* unchanged.
- Frame 0x3300FF: UNK_ADDR pulses, ERR_CNT=1, all shadow registers unchanged.
- Write 0x420055, then 0x000001:
  - shadow[12] reads 0.
  - shadow[0] reads 0001.
- Assert RST_N low after 10 bits of frame 0x11ABCD: no write; the next full frame 0x11ABCD commits with FRAME_CNT=1.
- With ADC_RESP_SYNC_EN defined, repeat scenario 1 with SDATA skewed by 0.3 CLK: identical result except WR_STB comes 4 CLK after CS falls.
